// File: rtl/addsub_scheduler_pkg.sv
// Shared constants for the add/sub scheduler: FSM encodings and default datapath width.
package addsub_scheduler_pkg;

   localparam int DEFAULT_N = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/addsub_scheduler_dp.sv
// Combinational N-bit two's-complement add/subtract with signed-overflow detect.
module addsub_dp #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] s,
   output logic         ovf
);

   logic [N-1:0] b_x;
   logic [N-1:0] low_sum;
   logic [N:0]   full_sum;
   logic         carry_in_msb;
   logic         carry_out_msb;

   assign b_x = b ^ {N{sub}};

   // Low N-1 bits summed separately so bit N-1 of the result is the carry into the MSB.
   assign low_sum  = {1'b0, a[N-2:0]} + {1'b0, b_x[N-2:0]} + {{(N-1){1'b0}}, sub};
   assign full_sum = {1'b0, a} + {1'b0, b_x} + {{N{1'b0}}, sub};

   assign carry_in_msb  = low_sum[N-1];
   assign carry_out_msb = full_sum[N];

   assign s   = full_sum[N-1:0];
   assign ovf = carry_in_msb ^ carry_out_msb;

endmodule

// File: rtl/addsub_scheduler_rr_arb2.sv
// Two-input round-robin arbiter; grants only while enabled, prefers the requester
// that did not win last time when both are asking.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       en,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       next_last
);

   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
         end else begin
            grant = req;
         end
      end
   end

   // Pointer only moves when somebody actually wins.
   always_comb begin
      next_last = last_grant;
      if (grant[1]) begin
         next_last = 1'b1;
      end else if (grant[0]) begin
         next_last = 1'b0;
      end
   end

endmodule

// File: rtl/addsub_scheduler.sv
// Shares one add/sub datapath between two requesters: round-robin grant in IDLE,
// compute in EXEC, hold a registered tagged result in RESP until it is taken.
module addsub_scheduler
   import addsub_scheduler_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req0_sub,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic         req1_sub,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic         resp_id,
   output logic [N-1:0] resp_s,
   output logic         resp_ovf
);

   // valid/ready: a request transfers on a rising edge where reqK_valid && reqK_ready;
   // the result transfers on an edge where resp_valid && resp_ready. Requesters hold
   // operands stable while waiting; resp_* stay stable while resp_ready is low.

   logic [1:0]   state;
   logic         last_grant;
   logic         next_last;
   logic [1:0]   grant;
   logic         arb_en;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic         op_sub;
   logic         op_id;
   logic [N-1:0] dp_s;
   logic         dp_ovf;

   // Gating with rst keeps both readys low while reset is held.
   assign arb_en = (state == ST_IDLE) && !rst;

   rr_arb2 u_arb (
      .req        ({req1_valid, req0_valid}),
      .en         (arb_en),
      .last_grant (last_grant),
      .grant      (grant),
      .next_last  (next_last)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   addsub_dp #(.N(N)) u_dp (
      .a   (op_a),
      .b   (op_b),
      .sub (op_sub),
      .s   (dp_s),
      .ovf (dp_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         op_sub     <= 1'b0;
         op_id      <= 1'b0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_s     <= '0;
         resp_ovf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  op_a       <= grant[1] ? req1_a   : req0_a;
                  op_b       <= grant[1] ? req1_b   : req0_b;
                  op_sub     <= grant[1] ? req1_sub : req0_sub;
                  op_id      <= grant[1];
                  last_grant <= next_last;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resp_s     <= dp_s;
               resp_ovf   <= dp_ovf;
               resp_id    <= op_id;
               resp_valid <= 1'b1;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/addsub_scheduler.md
# addsub_scheduler

Sequential controller that shares one N-bit signed add/subtract datapath between two requesters. Arbitrates round-robin, latches the winner's operands and opcode, and drives the datapath. Returns a registered sum/difference and signed-overflow flag through a valid/ready response port tagged with the requester ID. Sits between the ALU front-end command sources and the shared adder/subtractor.

## Interface
- N, default 16: operand and result width in bits (N ≥ 2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req0_valid, req1_valid  input  1 each  requester k has an operation pending.
- req0_ready, req1_ready  output  1 each  requester k's operation is accepted this cycle.
- req0_a, req0_b, req1_a, req1_b  input  N each  operands, two's complement.
- req0_sub, req1_sub  input  1 each  1 = a − b, 0 = a + b.
- resp_valid  output  1  result registers hold a valid result.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  1  requester that issued the result.
- resp_s  output  N  result, modulo 2^N.
- resp_ovf  output  1  signed overflow of the operation.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If no request is valid, stay in IDLE.
  - Otherwise grant one requester. Assert its reqK_ready for exactly that cycle, combinationally from valid and the priority pointer.
  - Capture a, b, sub and id into operand registers. Go to EXEC.
- Arbitration: a 1-bit last_grant register, reset to 1, so requester 0 wins first.
  - If only one requester is valid, grant it.
  - If both are valid, grant !last_grant.
  - last_grant updates only on a grant.
- EXEC:
  - The datapath computes s = a + (b XOR {N{sub}}) + sub.
  - ovf = carry into MSB XOR carry out of MSB.
  - Register s, ovf and id into the resp_* registers, set resp_valid, go to RESP.
- RESP:
  - Hold resp_* stable while resp_ready = 0.
  - When resp_valid && resp_ready, clear resp_valid and go to IDLE.
  - No new grant is made in RESP.
- reqK_ready is never asserted outside IDLE. At most one ready is high in any cycle.
- Request-side rule: requesters hold a, b and sub stable while valid is high and ready is low. A requester may drop valid without an acceptance; no grant results from a dropped valid.
- Carry-out is not exported. Unsigned wrap is silent.

## Timing
- Accept at edge T (IDLE, valid && ready). resp_valid rises after edge T+1. Result is visible in cycle T+2.
- Minimum issue interval is 3 cycles: IDLE → EXEC → RESP → IDLE with resp_ready held high.
- resp_ready high in the first RESP cycle: handshake completes there, FSM is in IDLE the next cycle.
- Reset, applied at any time including mid-EXEC or mid-RESP, takes effect asynchronously:
  - FSM returns to IDLE and last_grant returns to 1.
  - resp_valid, resp_id, resp_s and resp_ovf go to 0. Operand registers clear to 0.
  - reqK_ready goes to 0.
  - The in-flight operation is discarded.
- Reset deasserted with requests already pending: the first grant happens in the first clock cycle after release.

## Structure
- A shared include file holds the FSM state encodings (IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2) and the default width.
- Sub-module rr_arb2: a two-input round-robin arbiter.
  - Inputs: req[1:0], the enable (IDLE) and last_grant.
  - Outputs: a one-hot grant and the next last_grant.
- The add/sub datapath is a combinational N-bit instance fed from the operand registers. No other logic is inlined into it.

## Test plan
- Basic subtract: req0 with a = 1000, b = 999, sub = 1 → resp_s = 16'h0001, resp_ovf = 0, resp_id = 0; resp_valid rises 2 cycles after acceptance.
- Overflow cases:
  - 16'h7FFF + 16'h0001 (sub = 0) → resp_s = 16'h8000, resp_ovf = 1.
  - 16'h8000 − 16'h0001 → resp_s = 16'h7FFF, resp_ovf = 1.
  - 16'hFFFF + 16'h0001 → resp_s = 16'h0000, resp_ovf = 0.
- Fairness: both requesters valid continuously from reset, resp_ready = 1 → grants alternate 0, 1, 0, 1; resp_id follows the same order; never two readys in one cycle.
- Backpressure: resp_ready = 0 for 5 cycles after resp_valid → resp_s, resp_ovf and resp_id stay stable, no reqK_ready asserted; resp_ready = 1 → handshake completes, next grant in the following cycle.
- Reset mid-operation: assert rst during EXEC → all outputs 0 immediately, no response emitted; after release with req1 alone valid → req1 granted in the first cycle.
